// File: rtl/prng_led_scheduler_if.sv
// -----------------------------------------------------------------------------
// prng_led_scheduler_if
//   Groups the button input and the LED/status outputs of prng_led_scheduler.
//
//   Signals:
//     btn_raw     : raw asynchronous button, active-high (into the scheduler)
//     led_onboard : onboard LED, polarity chosen by the scheduler parameter
//     led_ext     : external LED, active-high
//     busy        : high whenever the scheduler is not idle
//     secs_left   : remaining ON seconds, 0 outside the ON phase
//     state_o     : IDLE=0, LOAD=1, ON=2, COOLDOWN=3
//
//   Modports:
//     master : the scheduler side (drives LEDs and status, reads the button)
//     slave  : the board / testbench side (drives the button, reads status)
// -----------------------------------------------------------------------------
interface prng_led_scheduler_if;
  logic       btn_raw;
  logic       led_onboard;
  logic       led_ext;
  logic       busy;
  logic [7:0] secs_left;
  logic [1:0] state_o;

  modport master (
    input  btn_raw,
    output led_onboard,
    output led_ext,
    output busy,
    output secs_left,
    output state_o
  );

  modport slave (
    output btn_raw,
    input  led_onboard,
    input  led_ext,
    input  busy,
    input  secs_left,
    input  state_o
  );
endinterface

// File: rtl/prng_led_scheduler.sv
// -----------------------------------------------------------------------------
// prng_led_scheduler
//   Button-triggered random-duration LED controller. The raw button is
//   synchronized and debounced; each accepted rising edge draws a duration of
//   MIN_S .. MIN_S+2^DUR_BITS-1 seconds from a free-running 16-bit Galois LFSR.
//   The LEDs stay on for that many whole seconds of a CLK_HZ-cycle timebase,
//   followed by a COOLDOWN_S second lockout during which presses are dropped.
//
//   Ports:
//     clk : system clock
//     rst : synchronous, active-high reset
//     io  : prng_led_scheduler_if.master
//             btn_raw (in), led_onboard, led_ext, busy, secs_left[7:0],
//             state_o[1:0] (out)
// -----------------------------------------------------------------------------
module prng_led_scheduler #(
  parameter int unsigned CLK_HZ          = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MIN_S           = 1,
  parameter int unsigned DUR_BITS        = 3,
  parameter int unsigned COOLDOWN_S      = 1,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter bit          LED_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  prng_led_scheduler_if.master  io
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int unsigned SYNC_STAGES = 2;

  localparam int unsigned PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // With no cooldown the counter is never used; keep it one bit wide.
  localparam int unsigned CD_W = (COOLDOWN_S > 1) ? $clog2(COOLDOWN_S) : 1;
  localparam logic [CD_W-1:0] CD_LAST = CD_W'((COOLDOWN_S > 0) ? (COOLDOWN_S - 1) : 0);

  // An all-zero seed would lock the LFSR up, so it is replaced.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [7:0] MIN_S8 = 8'(MIN_S);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    ON       = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  state_t            state_reg;
  state_t            state_next;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic              sync_out;

  logic              db_reg;
  logic              db_q_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic              press;

  logic [15:0]       lfsr_reg;
  logic [7:0]        load_secs;

  logic [PS_W-1:0]   ps_reg;
  logic              tick;
  logic              ps_clear;

  logic [CD_W-1:0]   cd_reg;
  logic              cd_done;

  logic [7:0]        secs_reg;
  logic              last_sec;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer: stage 0 samples the pin, each later stage samples
  // the one before it.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) begin
            sync_reg[0] <= 1'b0;
          end else begin
            sync_reg[0] <= io.btn_raw;
          end
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (rst) begin
            sync_reg[gi] <= 1'b0;
          end else begin
            sync_reg[gi] <= sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign sync_out = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce: the synchronized level must disagree with db for DEBOUNCE_CYCLES
  // consecutive cycles before db follows it. Any agreeing cycle restarts the
  // count, so short glitches never reach db.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      db_reg     <= 1'b0;
      db_q_reg   <= 1'b0;
      db_cnt_reg <= '0;
    end else begin
      db_q_reg <= db_reg;
      if (sync_out != db_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          db_reg     <= sync_out;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  // One-cycle pulse per accepted rising level.
  assign press = db_reg & ~db_q_reg;

  // ---------------------------------------------------------------------------
  // Free-running Galois LFSR (right shift). It keeps running in every state so
  // the duration drawn depends on when the user presses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED_EFF;
    end else begin
      lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign load_secs = MIN_S8 + 8'(lfsr_reg[DUR_BITS-1:0]);

  // ---------------------------------------------------------------------------
  // One-second timebase. Restarting it in LOAD and when ON finishes makes the
  // first ON second and the first cooldown second full length.
  // ---------------------------------------------------------------------------
  assign tick = (ps_reg == PS_LAST);

  // A loaded value of 0 (only possible with MIN_S=0) is treated like 1 so the
  // ON phase cannot underflow and run forever.
  assign last_sec = (secs_reg <= 8'd1);

  assign ps_clear = (state_reg == LOAD) || ((state_reg == ON) && tick && last_sec);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_reg <= '0;
    end else if (ps_clear || tick) begin
      ps_reg <= '0;
    end else begin
      ps_reg <= ps_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Cooldown second counter; only advances on ticks while in COOLDOWN.
  // ---------------------------------------------------------------------------
  assign cd_done = tick && (cd_reg == CD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cd_reg <= '0;
    end else if (state_reg == COOLDOWN) begin
      if (cd_done) begin
        cd_reg <= '0;
      end else if (tick) begin
        cd_reg <= cd_reg + 1'b1;
      end
    end else begin
      cd_reg <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Seconds remaining: loaded at the end of LOAD, counted down on ON ticks,
  // held at zero everywhere else.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      secs_reg <= 8'd0;
    end else begin
      case (state_reg)
        LOAD: secs_reg <= load_secs;
        ON: begin
          if (tick) begin
            secs_reg <= last_sec ? 8'd0 : (secs_reg - 8'd1);
          end
        end
        default: secs_reg <= 8'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Presses are only looked at in IDLE, so anything
  // arriving in LOAD, ON or COOLDOWN is simply lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (press) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        state_next = ON;
      end
      ON: begin
        if (tick && last_sec) begin
          state_next = (COOLDOWN_S == 0) ? IDLE : COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cd_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded straight from the state register.
  // ---------------------------------------------------------------------------
  always_comb begin
    io.led_ext     = 1'b0;
    io.busy        = 1'b0;
    io.state_o     = state_reg;
    io.secs_left   = secs_reg;
    if (state_reg == ON) begin
      io.led_ext = 1'b1;
    end
    if (state_reg != IDLE) begin
      io.busy = 1'b1;
    end
    io.led_onboard = io.led_ext ^ LED_ACTIVE_LOW;
  end

endmodule

// File: tb/tb_prng_led_scheduler.sv
// -----------------------------------------------------------------------------
// tb_prng_led_scheduler
//   Drives two schedulers (cooldown 1 s and cooldown 0 s) with randomized
//   button timing and checks every cycle against a timeline predicted from
//   the press latency / duration rules and a reference LFSR.
// -----------------------------------------------------------------------------
module tb_prng_led_scheduler;
  localparam int          CLK_HZ   = 10;
  localparam int          DEB      = 4;
  localparam int          MIN_S    = 1;
  localparam int          DUR_BITS = 3;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  prng_led_scheduler_if if0();
  prng_led_scheduler_if if1();

  prng_led_scheduler #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .MIN_S(MIN_S), .DUR_BITS(DUR_BITS),
    .COOLDOWN_S(1), .LFSR_SEED(SEED), .LED_ACTIVE_LOW(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .io(if0)
  );

  prng_led_scheduler #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB), .MIN_S(MIN_S), .DUR_BITS(DUR_BITS),
    .COOLDOWN_S(0), .LFSR_SEED(SEED), .LED_ACTIVE_LOW(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .io(if1)
  );

  // Reference LFSR: seed on reset edges, one Galois step on every other edge.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {state_o, led_ext, led_onboard, busy, secs_left}
  function automatic logic [12:0] obs(input bit sel);
    if (sel) return {if1.state_o, if1.led_ext, if1.led_onboard, if1.busy, if1.secs_left};
    return {if0.state_o, if0.led_ext, if0.led_onboard, if0.busy, if0.secs_left};
  endfunction

  function automatic logic [12:0] mk(input logic [1:0] st, input logic [7:0] s);
    logic on;
    on = (st == 2'd2);
    return {st, on, ~on, (st != 2'd0), s};
  endfunction

  task automatic set_btn(input bit sel, input logic v);
    if (sel) if1.btn_raw = v;
    else     if0.btn_raw = v;
  endtask

  task automatic idle_gap(input bit sel, input int n);
    set_btn(sel, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("gap_idle", 32'(obs(sel)), 32'(mk(2'd0, 8'd0)));
    end
  endtask

  // One press transaction. t counts edges from edge k (first edge sampling the
  // button high). Optional extras: lockout presses, reset mid-ON, and a chained
  // press landing one cycle after IDLE is re-entered.
  task automatic run_press(input bit sel, input int hold, input bit lock,
                           input int rst_at, input bit chain, output bit did);
    int e_secs, e2, t_cs, t_idle, t_end, p2s, p2e, p3s, p3e;
    bit b, in_rst;
    logic [1:0] st;
    logic [7:0] s;
    string tag;
    did = 0; in_rst = 0; e_secs = 0; e2 = 0;
    t_cs = 1000; t_idle = 1000; t_end = 1000;
    p2s = -1; p2e = -1; p3s = -1; p3e = -1;
    for (int t = 0; t <= t_end; t++) begin
      b = (t < hold) || (t >= p2s && t < p2e) || (t >= p3s && t < p3e);
      set_btn(sel, b);
      if (rst_at >= 0 && t_cs != 1000 && t == 7 + rst_at && t < t_cs) begin
        rst = 1'b1;
        in_rst = 1;
      end
      @(negedge clk);
      if (in_rst) begin
        check_eq("rst_mid_on", 32'(obs(sel)), 32'(mk(2'd0, 8'd0)));
        set_btn(sel, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("rst_held", 32'(obs(sel)), 32'(mk(2'd0, 8'd0)));
        rst = 1'b0;
        did = 1;
        break;
      end
      if (t < 6) begin
        st = 2'd0; s = 8'd0; tag = "pre_load";
      end else if (t == 6) begin
        st = 2'd1; s = 8'd0; tag = "load";
        e_secs = MIN_S + int'(m_lfsr[DUR_BITS-1:0]);
        t_cs   = 7 + e_secs * CLK_HZ;
        t_idle = sel ? t_cs : t_cs + CLK_HZ;
        t_end  = chain ? t_idle + 3 : t_idle + 12;
        if (lock && e_secs >= 2) begin
          p2s = 14; p2e = 22; p3s = t_cs + 1; p3e = t_cs + 13; did = 1;
        end
        if (chain) begin
          p2s = t_idle - 4; p2e = t_idle; did = 1;
        end
      end else if (t < t_cs) begin
        st = 2'd2; s = 8'(e_secs - (t - 7) / CLK_HZ); tag = "on";
      end else if (t < t_idle) begin
        st = 2'd3; s = 8'd0; tag = "cooldown";
      end else if (chain && t == t_idle + 2) begin
        st = 2'd1; s = 8'd0; tag = "chain_load";
        e2 = MIN_S + int'(m_lfsr[DUR_BITS-1:0]);
      end else if (chain && t == t_idle + 3) begin
        st = 2'd2; s = 8'(e2); tag = "chain_on";
      end else begin
        st = 2'd0; s = 8'd0; tag = "post_idle";
      end
      check_eq($sformatf("%s_t%0d", tag, t), 32'(obs(sel)), 32'(mk(st, s)));
    end
    set_btn(sel, 1'b0);
    if (chain) begin
      for (int i = 0; i < 200 && obs(sel)[12:11] != 2'd0; i++) @(negedge clk);
      check_eq("chain_drain", 32'(obs(sel)[12:11]), 32'd0);
    end
    $display("press dut=%0d hold=%0d secs=%0d lock=%0d rst_at=%0d chain=%0d extra=%0d",
             sel, hold, e_secs, lock, rst_at, chain, did);
  endtask

  initial begin
    bit did;
    int n;
    if0.btn_raw = 1'b0;
    if1.btn_raw = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_dut0", 32'(obs(0)), 32'(mk(2'd0, 8'd0)));
    check_eq("reset_dut1", 32'(obs(1)), 32'(mk(2'd0, 8'd0)));
    rst = 1'b0;

    // Glitches shorter than the debounce window must be rejected.
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, DEB - 1);
      set_btn(0, 1'b1);
      repeat (n) @(negedge clk);
      set_btn(0, 1'b0);
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        check_eq("glitch_idle", 32'(obs(0)), 32'(mk(2'd0, 8'd0)));
      end
      $display("glitch len=%0d", n);
    end

    // Clean presses at random times.
    for (int i = 0; i < 4; i++) begin
      idle_gap(0, $urandom_range(5, 40));
      run_press(0, 20, 1'b0, -1, 1'b0, did);
    end

    // Lockout: extra presses in ON and COOLDOWN (needs a duration >= 2 s).
    did = 0;
    for (int i = 0; i < 20 && !did; i++) begin
      idle_gap(0, $urandom_range(5, 40));
      run_press(0, 8, 1'b1, -1, 1'b0, did);
    end

    // Reset during the 15th ON cycle, then a fresh press from the seed.
    did = 0;
    for (int i = 0; i < 20 && !did; i++) begin
      idle_gap(0, $urandom_range(5, 40));
      run_press(0, 20, 1'b0, 14, 1'b0, did);
    end
    idle_gap(0, $urandom_range(3, 10));
    run_press(0, 20, 1'b0, -1, 1'b0, did);

    // Zero cooldown instance.
    for (int i = 0; i < 2; i++) begin
      idle_gap(1, $urandom_range(5, 40));
      run_press(1, 20, 1'b0, -1, 1'b0, did);
    end
    idle_gap(1, $urandom_range(5, 40));
    run_press(1, 8, 1'b0, -1, 1'b1, did);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prng_led_scheduler.md
Name: prng_led_scheduler

Overview:
- Controller that sequences the button-triggered random-duration LED datapath on the Colorlight i9.
- Synchronizes and debounces the raw button, then draws a duration from a free-running 16-bit LFSR.
- Runs a 1 s timebase and drives the onboard and external LEDs for MIN_S..MIN_S+2^DUR_BITS-1 seconds.
- After each ON period it enforces a cooldown lockout before the next press is accepted.

Parameters:
- CLK_HZ, 25000000: clock frequency; one tick every CLK_HZ cycles.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a level change (10 ms).
- MIN_S, 1: minimum ON duration in seconds.
- DUR_BITS, 3: number of LFSR bits added to MIN_S. Constraint: MIN_S + 2^DUR_BITS - 1 <= 255.
- COOLDOWN_S, 1: lockout seconds after ON; 0 means no cooldown.
- LFSR_SEED, 16'hACE1: LFSR reset value; a seed of 0 is replaced by 16'h0001.
- LED_ACTIVE_LOW, 1: polarity of led_onboard.

Ports:
- clk, in, 1: system clock, 25 MHz.
- rst, in, 1: synchronous, active-high reset.
- btn_raw, in, 1: asynchronous raw button, active-high.
- led_onboard, out, 1: onboard LED; polarity set by LED_ACTIVE_LOW.
- led_ext, out, 1: external LED, active-high.
- busy, out, 1: high whenever state != IDLE.
- secs_left, out, 8: remaining ON seconds; 0 outside ON.
- state_o, out, 2: IDLE=0, LOAD=1, ON=2, COOLDOWN=3.

Behaviour:
- Reset, sampled on clk rise while rst=1:
  - state=IDLE, secs_left=0.
  - Synchronizer flops=0, debounced level db=0, db_q=0, debounce counter=0.
  - Prescaler=0, cooldown counter=0, LFSR=LFSR_SEED.
  - Outputs: led_ext=0, busy=0, led_onboard=LED_ACTIVE_LOW.
  - rst overrides everything in the same cycle, including mid-ON and mid-COOLDOWN.
- Synchronizer: two-flop chain sync1 -> sync2.
- Debounce:
  - While sync2 != db, the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and a mismatch persists: db <= sync2 and the counter clears.
  - Any cycle with sync2 == db clears the counter, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Press pulse: press = db & ~db_q (db_q is db delayed one cycle). Exactly one cycle per accepted rising level.
- LFSR:
  - Galois, right-shift: lfsr <= {1'b0,lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0).
  - Advances every cycle out of reset; period 65535; never reaches 0.
- Prescaler and tick:
  - Counts 0..CLK_HZ-1; tick=1 when count == CLK_HZ-1, then wraps to 0.
  - Cleared in LOAD and on the ON->COOLDOWN transition, so every second is a full CLK_HZ cycles.
- FSM:
  - IDLE: LEDs off. On press -> LOAD.
  - LOAD (exactly 1 cycle): secs_left <= MIN_S + lfsr[DUR_BITS-1:0], using the LFSR value present in the LOAD cycle. Then -> ON.
  - ON: LEDs on. On tick, secs_left decrements.
    - On a tick with secs_left == 1: secs_left <= 0.
    - Then -> COOLDOWN, or -> IDLE if COOLDOWN_S == 0.
  - COOLDOWN: LEDs off. The cooldown counter counts ticks; at the COOLDOWN_S-th tick -> IDLE and the counter clears.
- Press handling outside IDLE: presses in LOAD, ON or COOLDOWN are dropped, not queued.
  - A button held across COOLDOWN->IDLE does not retrigger; a new rising db edge is required.
  - A button still high after rst deassertion is debounced and produces one press.
- LED outputs:
  - led_ext = (state == ON).
  - led_onboard = led_ext ^ LED_ACTIVE_LOW.
  - Both decode combinationally from the state register; no extra latency.
- Latency:
  - Let edge k be the first clk edge that samples btn_raw=1 into sync1, with the button held stable.
  - db rises at edge k+1+DEBOUNCE_CYCLES.
  - LOAD is entered at edge k+2+DEBOUNCE_CYCLES.
  - led_ext goes high after edge k+3+DEBOUNCE_CYCLES.
  - led_ext stays high exactly secs_left_loaded * CLK_HZ cycles.
  - COOLDOWN lasts exactly COOLDOWN_S * CLK_HZ cycles.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=10, DEBOUNCE_CYCLES=4, MIN_S=1, DUR_BITS=3, COOLDOWN_S=1, LFSR_SEED=16'hACE1. The bench carries a reference LFSR model.
- Reset: rst high 3 cycles -> led_ext=0, led_onboard=1, busy=0, secs_left=0, state_o=0; model LFSR equals 16'hACE1 after reset.
- Glitch rejection: btn_raw high 3 cycles, then low -> db never rises, state_o stays 0, led_ext stays 0.
- Clean press: btn_raw high 20 cycles at edge k -> LOAD at edge k+6, led_ext high from edge k+7. secs_left = 1 + model_lfsr[2:0] (range 1..8). led_ext high exactly secs_left*10 cycles, then COOLDOWN for 10 cycles, then IDLE.
- Lockout: second press during ON and third press during COOLDOWN -> both ignored; secs_left decrements unchanged; no extra ON period.
- Reset mid-ON: assert rst at the 15th ON cycle -> next cycle state_o=0, led_ext=0, secs_left=0; a later press restarts from LFSR seed timing.
- Zero cooldown (COOLDOWN_S=0): press -> ON then directly IDLE after the final tick; a press 1 cycle after entering IDLE is accepted.
